rx_buffer_reader: RTL and testbench

RX_BUFFER_READER -- requirements
Module: rx_buffer_reader

---
 rtl/rx_buffer_reader.sv | 136 +++++++++++++
 tb/tb_rx_buffer_reader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rx_buffer_reader.sv
// rx_buffer_reader: drains length-prefixed packets from a word buffer into a stream; define RX_READER_LEN_CHECK_EN to flush bad-length headers
module rx_buffer_reader #(
  parameter int AW = 9,
  parameter int MAX_BYTES = 1518
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW:0]   commited_wr_address,
  output logic [AW-1:0] rd_addr,
  output logic          rd_en,
  input  logic [63:0]   rd_data,
  output logic [AW:0]   rd_addr_extended,
  output logic          rd_addr_change,
  output logic [63:0]   out_data,
  output logic [7:0]    out_be,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   pkt_count,
  output logic [31:0]   len_err_count
);
`ifdef RX_READER_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, HDR, STREAM, DONE} state_t;
  state_t state, state_nxt;
  logic [AW:0] ptr, rd_word;
  logic [31:0] n_hdr;
  logic [32:0] n_sum;
  logic [29:0] w_hdr, w, widx;
  logic [2:0] n_lo;
  logic [1:0] occ;
  logic bad, pop, issue, i_sop, i_eop;
  logic [7:0] i_be, inf_be, sk_be;
  logic inf_v, inf_sop, inf_eop, sk_v, sk_sop, sk_eop;
  logic [63:0] sk_data;
  assign rd_addr_extended = ptr;
  // header decode, holding-buffer occupancy and read-issue qualification
  always_comb begin
    n_hdr = rd_data[63:32];
    n_sum = {1'b0, n_hdr} + 33'd7;
    w_hdr = n_sum[32:3];
    bad = LEN_CHK && (n_hdr == 32'd0 || n_hdr > 32'(MAX_BYTES));
    pop = out_valid && out_ready;
    occ = {1'b0, out_valid} + {1'b0, sk_v} + {1'b0, inf_v};
    issue = state == STREAM && widx != w && occ < 2'd2 + {1'b0, pop};
    i_sop = widx == 30'd0;
    i_eop = widx == w - 30'd1;
    i_be = (i_eop && n_lo != 3'd0) ? 8'hFF >> (3'd0 - n_lo) : 8'hFF;
  end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_nxt = state == IDLE ? (ptr != commited_wr_address ? HDR : IDLE) :
                state == HDR ? (bad ? IDLE : (w_hdr == 30'd0 ? DONE : STREAM)) :
                state == STREAM ? ((pop && out_eop) ? DONE : STREAM) : IDLE;
  end
  // buffer read port: header read from IDLE, data reads from STREAM
  always_comb begin
    rd_word = ptr + (AW+1)'(1) + (AW+1)'(widx);
    rd_en = !reset && (state == IDLE ? ptr != commited_wr_address : issue);
    rd_addr = state == IDLE ? ptr[AW-1:0] : rd_word[AW-1:0];
  end
  // packet bookkeeping, read pipeline and 2-entry output holding buffer
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      rd_addr_change <= 1'b0;
      pkt_count <= '0;
      len_err_count <= '0;
      n_lo <= '0;
      w <= '0;
      widx <= '0;
      inf_v <= 1'b0;
      inf_sop <= 1'b0;
      inf_eop <= 1'b0;
      inf_be <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_be <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      sk_v <= 1'b0;
      sk_data <= '0;
      sk_be <= '0;
      sk_sop <= 1'b0;
      sk_eop <= 1'b0;
    end else begin
      rd_addr_change <= 1'b0;
      if (state == HDR) begin
        n_lo <= n_hdr[2:0];
        w <= w_hdr;
        widx <= '0;
      end
      if (state == HDR && bad) begin
        ptr <= commited_wr_address;
        rd_addr_change <= 1'b1;
        len_err_count <= len_err_count + 32'd1;
      end
      if (state == DONE) begin
        ptr <= ptr + (AW+1)'(1) + (AW+1)'(w);
        rd_addr_change <= 1'b1;
        pkt_count <= pkt_count + {31'd0, w != 30'd0};
      end
      if (issue) widx <= widx + 30'd1;
      inf_v <= issue;
      inf_sop <= i_sop;
      inf_eop <= i_eop;
      inf_be <= i_be;
      if (pop && sk_v) begin
        out_data <= sk_data;
        out_be <= sk_be;
        out_sop <= sk_sop;
        out_eop <= sk_eop;
      end else if (inf_v && (!out_valid || pop)) begin
        out_data <= rd_data;
        out_be <= inf_be;
        out_sop <= inf_sop;
        out_eop <= inf_eop;
      end
      if (inf_v && out_valid && pop == sk_v) begin
        sk_data <= rd_data;
        sk_be <= inf_be;
        sk_sop <= inf_sop;
        sk_eop <= inf_eop;
      end
      out_valid <= out_valid ? (!pop || sk_v || inf_v) : inf_v;
      sk_v <= pop ? (sk_v && inf_v) : (sk_v || (inf_v && out_valid));
    end
endmodule

// File: tb/tb_rx_buffer_reader.sv
// tb_rx_buffer_reader: directed scoreboard bench for rx_buffer_reader
module tb_rx_buffer_reader;
  localparam int AW = 9;
  logic clk = 1'b0, reset = 1'b1, out_ready = 1'b1;
  logic rd_en, rd_addr_change, out_sop, out_eop, out_valid;
  logic [AW:0] commited_wr_address = '0, rd_addr_extended;
  logic [AW-1:0] rd_addr;
  logic [63:0] rd_data = '0, out_data;
  logic [7:0] out_be;
  logic [31:0] pkt_count, len_err_count;
  logic [63:0] mem [0:511];
  logic [73:0] exp_q [$];
  logic [73:0] e;
  int raddr_q [$];
  bit rec = 1'b0;
  int total = 0, passes = 0, fails = 0, words = 0;
  logic stalled = 1'b0;
  logic [74:0] held = '0;

  always #5 clk = ~clk;

  rx_buffer_reader #(.AW(AW), .MAX_BYTES(1518)) dut (
    .clk(clk), .reset(reset), .commited_wr_address(commited_wr_address),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_addr_extended(rd_addr_extended), .rd_addr_change(rd_addr_change),
    .out_data(out_data), .out_be(out_be), .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .pkt_count(pkt_count), .len_err_count(len_err_count)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // buffer model: one-cycle read latency
  always @(posedge clk)
    if (rd_en) begin
      rd_data <= mem[rd_addr];
      if (rec) raddr_q.push_back(int'(rd_addr));
    end

  // output monitor: scoreboard pop on transfer, hold check during stalls
  always @(negedge clk) begin
    if (reset) stalled = 1'b0;
    else begin
      if (stalled)
        chk("stall_hold", 96'({out_valid, out_data, out_be, out_sop, out_eop}), 96'(held));
      if (out_valid && out_ready) begin
        words++;
        chk("word_expected", 96'(exp_q.size() != 0), 96'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word", 96'({out_data, out_be, out_sop, out_eop}), 96'(e));
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_valid, out_data, out_be, out_sop, out_eop};
    end
  end

  task automatic load_pkt(input int s, input int n, input int cw);
    int wn;
    logic [63:0] d;
    logic [7:0] be;
    wn = (n + 7) / 8;
    mem[s % 512] = {32'(n), 32'($urandom)};
    for (int i = 0; i < wn; i++) begin
      d = {$urandom, $urandom};
      mem[(s + 1 + i) % 512] = d;
      be = (i == wn - 1 && n % 8 != 0) ? 8'((1 << (n % 8)) - 1) : 8'hFF;
      exp_q.push_back({d, be, 1'(i == 0), 1'(i == wn - 1)});
    end
    commited_wr_address = (AW+1)'(cw);
  endtask

  task automatic wait_done(input string tag, input int exp_ext, input bit tgl);
    int k;
    k = 0;
    while (!rd_addr_change && k < 3000) begin
      @(posedge clk); #1;
      if (tgl) out_ready = ~out_ready;
      k++;
    end
    out_ready = 1'b1;
    chk({tag, "_chg"}, 96'(rd_addr_change), 96'(1));
    chk({tag, "_ext"}, 96'(rd_addr_extended), 96'(exp_ext));
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 96'(rd_addr_change), 96'(0));
    chk({tag, "_drained"}, 96'(exp_q.size()), 96'(0));
  endtask

  initial begin
    int k, w0, pk;
    bit chg_seen;
    int exp_a [4];
    exp_a = '{510, 511, 0, 1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 96'(out_valid), 96'(0));
    chk("rst_rd_en", 96'(rd_en), 96'(0));
    chk("rst_rd_addr", 96'(rd_addr), 96'(0));
    chk("rst_ext", 96'(rd_addr_extended), 96'(0));
    chk("rst_chg", 96'(rd_addr_change), 96'(0));
    chk("rst_pkt", 96'(pkt_count), 96'(0));
    chk("rst_lenerr", 96'(len_err_count), 96'(0));
    chk("rst_out", 96'({out_data, out_be, out_sop, out_eop}), 96'(0));
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    load_pkt(0, 64, 9);
    k = 0;
    while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("first_valid_latency", 96'(k), 96'(4));
    wait_done("n64", 9, 1'b0);
    chk("n64_pkt", 96'(pkt_count), 96'(1));
    load_pkt(9, 61, 18);
    wait_done("n61", 18, 1'b0);
    chk("n61_pkt", 96'(pkt_count), 96'(2));
    load_pkt(18, 64, 27);
    wait_done("stall", 27, 1'b1);
    chk("stall_pkt", 96'(pkt_count), 96'(3));
    w0 = words;
`ifdef RX_READER_LEN_CHECK_EN
    mem[27] = {32'd2000, 32'd0};
    commited_wr_address = 10'd40;
    wait_done("bad", 40, 1'b0);
    chk("bad_no_words", 96'(words - w0), 96'(0));
    chk("bad_lenerr", 96'(len_err_count), 96'(1));
    chk("bad_pkt", 96'(pkt_count), 96'(3));
    mem[40] = {32'd0, 32'd0};
    commited_wr_address = 10'd510;
    wait_done("bad0", 510, 1'b0);
    chk("bad0_lenerr", 96'(len_err_count), 96'(2));
    pk = 3;
`else
    mem[27] = {32'd0, 32'hDEAD_BEEF};
    commited_wr_address = 10'd28;
    wait_done("n0", 28, 1'b0);
    chk("n0_no_words", 96'(words - w0), 96'(0));
    chk("n0_pkt", 96'(pkt_count), 96'(3));
    chk("n0_lenerr", 96'(len_err_count), 96'(0));
    load_pkt(28, 3848, 510);
    wait_done("big", 510, 1'b0);
    pk = 4;
`endif
    chk("pre_wrap_pkt", 96'(pkt_count), 96'(pk));
    raddr_q.delete();
    rec = 1'b1;
    load_pkt(510, 24, 514);
    wait_done("wrap", 514, 1'b0);
    rec = 1'b0;
    chk("wrap_reads", 96'(raddr_q.size()), 96'(4));
    for (int i = 0; i < 4 && i < raddr_q.size(); i++)
      chk("wrap_addr", 96'(raddr_q[i]), 96'(exp_a[i]));
    chk("wrap_pkt", 96'(pkt_count), 96'(pk + 1));
    load_pkt(514, 64, 523);
    w0 = words;
    k = 0;
    while (words < w0 + 4 && k < 200) begin @(negedge clk); #1; k++; end
    chk("mid_words", 96'(words - w0), 96'(4));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_valid", 96'(out_valid), 96'(0));
    chk("mid_out", 96'({out_data, out_be, out_sop, out_eop}), 96'(0));
    chk("mid_rd_en", 96'(rd_en), 96'(0));
    chk("mid_rd_addr", 96'(rd_addr), 96'(0));
    chk("mid_ext", 96'(rd_addr_extended), 96'(0));
    chk("mid_chg", 96'(rd_addr_change), 96'(0));
    chk("mid_pkt", 96'(pkt_count), 96'(0));
    exp_q.delete();
    commited_wr_address = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    w0 = words;
    chg_seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chg_seen |= rd_addr_change;
    end
    chk("post_rst_words", 96'(words - w0), 96'(0));
    chk("post_rst_chg", 96'(chg_seen), 96'(0));
    chk("post_rst_pkt", 96'(pkt_count), 96'(0));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
